// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1-style UART receiver with 2-flop synchronizer and break
//            handling. Define UART_RX_MAJORITY_EN for 2-of-3 sample voting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int WIDTH  = 8,
  parameter int CLKDIV = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  output logic [WIDTH-1:0] data,
  output logic             received,
  output logic             frame_err,
  output logic             busy
);

  localparam int c_CW = $clog2(CLKDIV);
  localparam int c_IW = $clog2(WIDTH + 1);
  localparam logic [c_CW-1:0] c_HALF     = c_CW'(CLKDIV / 2 - 1);
  localparam logic [c_CW-1:0] c_LAST     = c_CW'(CLKDIV - 1);
  localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sync1;
  logic             r_sync2;
  logic             w_rx_s;
  logic             w_sample;
  logic [c_CW-1:0]  r_cnt;
  logic [c_CW-1:0]  w_cnt_nxt;
  logic [c_IW-1:0]  r_idx;
  logic [c_IW-1:0]  w_idx_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nxt;
  logic             r_recv;
  logic             w_recv_nxt;
  logic             r_ferr;
  logic             w_ferr_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

`ifdef UART_RX_MAJORITY_EN
  // r_hist[0] tracks r_sync2, so the vote covers rx_s now and the two cycles before.
  logic [2:0] r_hist;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hist <= 3'b111;
    end else begin
      r_hist <= {r_hist[1:0], r_sync1};
    end
  end

  assign w_sample = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) |
                    (r_hist[1] & r_hist[2]);
`else
  assign w_sample = w_rx_s;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_recv  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_recv  <= w_recv_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + c_CW'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_recv_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx_s) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_cnt == c_HALF) begin
          if (w_sample) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DATA;
            w_idx_nxt   = '0;
          end
        end
      end
      S_DATA: begin
        if (r_cnt == c_LAST) begin
          w_shift_nxt = {w_sample, r_shift[WIDTH-1:1]};
          w_cnt_nxt   = '0;
          if (r_idx == c_IDX_LAST) begin
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_idx + c_IW'(1);
          end
        end
      end
      S_STOP: begin
        if (r_cnt == c_LAST) begin
          if (w_sample) begin
            w_data_nxt  = r_shift;
            w_recv_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // A held-low line is a break, not a new start bit.
        w_cnt_nxt = '0;
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end
  end

  assign data      = r_data;
  assign received  = r_recv;
  assign frame_err = r_ferr;
  assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Scoreboard bench for uart_rx (WIDTH=8, CLKDIV=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int WIDTH  = 8;
  localparam int CLKDIV = 16;
  // 2 sync + 8 start + 9*16 data/stop, observed one cycle after the update
  localparam int LAT    = 155;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             rx;
  logic [WIDTH-1:0] data;
  logic             received;
  logic             frame_err;
  logic             busy;

  uart_rx #(.WIDTH(WIDTH), .CLKDIV(CLKDIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .received  (received),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] d;
    int         t;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // ev: 0 = no event expected, 1 = received, 2 = frame_err
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic [9:0] gmask,
                            input int n_off, input int ev, input logic [7:0] exp_d);
    logic v;
    int   bi;
    for (int off = 0; off < n_off; off++) begin
      @(negedge clk);
      if (off == 0 && ev != 0) begin
        exp_t e;
        e.is_err = (ev == 2);
        e.d      = exp_d;
        e.t      = cyc + LAT;
        sbq.push_back(e);
      end
      bi = off / CLKDIV;
      if (bi == 0)      v = 1'b0;
      else if (bi <= 8) v = b[bi-1];
      else              v = stop_v;
      if ((off % CLKDIV) == CLKDIV / 2 && gmask[bi]) v = ~v;
      rx = v;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && (received === 1'b1 || frame_err === 1'b1)) begin
        check("pulse_exclusive", {31'd0, received & frame_err}, 32'd0);
        if (sbq.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_pulse: received=%0b frame_err=%0b at cycle %0d, none required",
                   received, frame_err, cyc);
        end else begin
          e = sbq.pop_front();
          check("pulse_kind", {31'd0, frame_err}, {31'd0, e.is_err});
          check("data", {24'd0, data}, {24'd0, e.d});
          n_chk++;
          if (cyc < e.t - 1 || cyc > e.t + 1) begin
            n_err++;
            $display("FAIL latency: pulse at cycle %0d, required %0d +-1", cyc, e.t);
          end
        end
      end
    end
  end

  initial begin
    logic [9:0] gm;
    logic [7:0] g_exp;

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_received", {31'd0, received}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle(10);

    // Single frame 0xA5
    send_frame(8'hA5, 1'b1, 10'd0, 160, 1, 8'hA5);
    idle(20);

    // Back-to-back 0x00 then 0xFF
    send_frame(8'h00, 1'b1, 10'd0, 160, 1, 8'h00);
    send_frame(8'hFF, 1'b1, 10'd0, 160, 1, 8'hFF);
    idle(20);

    // 4-cycle start glitch must be rejected
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    idle(2);
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    idle(10);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    send_frame(8'h3C, 1'b1, 10'd0, 160, 1, 8'h3C);
    idle(20);

    // Stop bit low, line held low: one frame_err, data keeps 0x3C
    send_frame(8'h55, 1'b0, 10'd0, 160, 2, 8'h3C);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    check("break_busy", {31'd0, busy}, 32'd1);
    idle(6);
    check("break_exit_busy", {31'd0, busy}, 32'd0);
    idle(20);

    // Reset in the middle of data bit 4 of 0x81
    send_frame(8'h81, 1'b1, 10'd0, 88, 0, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    @(negedge clk);
    check("midrst_data", {24'd0, data}, 32'd0);
    check("midrst_received", {31'd0, received}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle(20);
    send_frame(8'h42, 1'b1, 10'd0, 160, 1, 8'h42);
    idle(20);

    // One-cycle inverted glitch at each sample point of 0x96
`ifdef UART_RX_MAJORITY_EN
    gm    = 10'b11_1111_1111;
    g_exp = 8'h96;
`else
    gm    = 10'b01_1111_1110;
    g_exp = 8'h69;
`endif
    send_frame(8'h96, 1'b1, gm, 160, 1, g_exp);
    idle(20);

    for (int i = 0; i < 400 && sbq.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
